// File: rtl/ones_comp_checksum_checker_pkg.sv
// Shared types and helpers for the ones' complement checksum checker.
// Holds the FSM state encoding and the saturating statistics counter helper.
package ones_comp_checksum_checker_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StReport = 2'd2
    } state_e;

    localparam int unsigned StatsWidth = 16;
    localparam logic [StatsWidth-1:0] StatsMax = '1;

    function automatic logic [StatsWidth-1:0] sat_inc(input logic [StatsWidth-1:0] v);
        return (v == StatsMax) ? v : v + StatsWidth'(1);
    endfunction

endpackage

// File: rtl/ones_comp_checksum_checker_add_w.sv
// Combinational WIDTH-bit ones' complement adder with end-around carry.
// A single fold is enough: the folded carry can never produce a second carry out.
module ones_comp_add_w #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};
    assign sum = raw[WIDTH-1:0] + WIDTH'(raw[WIDTH]);

endmodule

// File: rtl/ones_comp_checksum_checker.sv
// Streaming ones' complement checksum checker: accumulates a packet and reports pass/fail.
// Optional ONES_CHK_STATS_EN adds saturating packet and error counters.
module ones_comp_checksum_checker
    import ones_comp_checksum_checker_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_WORDS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ok,
`ifdef ONES_CHK_STATS_EN
    output logic [15:0]      pkt_cnt,
    output logic [15:0]      err_cnt,
`endif
    output logic             out_len_err
);

    localparam int unsigned CntWidth = $clog2(MAX_WORDS + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MAX_WORDS);
    localparam logic [WIDTH-1:0] OnesZeroNeg = '1;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    acc_q, acc_d, acc_next;
    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_next;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic                ok_q, ok_d;
    logic                len_err_q, len_err_d;
    logic                accept;
    logic                at_limit;

    ones_comp_add_w #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (acc_next)
    );

    assign in_ready  = (state_q != StReport);
    assign out_valid = (state_q == StReport);
    assign accept    = in_valid & in_ready;
    assign cnt_next  = cnt_q + CntWidth'(1);
    assign at_limit  = (cnt_next == MaxCnt);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        ok_d      = ok_q;
        len_err_d = len_err_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    if (in_last || at_limit) begin
                        // Reaching the limit without in_last is the only other way in here.
                        state_d   = StReport;
                        sum_d     = acc_next;
                        len_err_d = !in_last;
                        ok_d      = in_last && (acc_next == OnesZeroNeg);
                    end else begin
                        state_d = StAccum;
                        acc_d   = acc_next;
                        cnt_d   = cnt_next;
                    end
                end
            end
            StReport: begin
                if (out_ready) begin
                    state_d = StIdle;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            ok_q      <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            ok_q      <= ok_d;
            len_err_q <= len_err_d;
        end
    end

    assign out_sum     = sum_q;
    assign out_ok      = ok_q;
    assign out_len_err = len_err_q;

`ifdef ONES_CHK_STATS_EN
    logic [StatsWidth-1:0] pkt_q, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
            err_q <= '0;
        end else if (out_valid && out_ready) begin
            pkt_q <= sat_inc(pkt_q);
            if (!ok_q) begin
                err_q <= sat_inc(err_q);
            end
        end
    end

    assign pkt_cnt = pkt_q;
    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_ones_comp_checksum_checker.sv
// Self-checking bench for ones_comp_checksum_checker (WIDTH=4, MAX_WORDS=4).
// Table vectors, corner-case sequences and random packets against a folding-sum model.
module tb_ones_comp_checksum_checker;

    localparam int unsigned W  = 4;
    localparam int unsigned MW = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_ok;
    logic         out_len_err;

    int checks = 0;
    int errors = 0;

    ones_comp_checksum_checker #(
        .WIDTH     (W),
        .MAX_WORDS (MW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_ok      (out_ok),
        .out_len_err (out_len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 n;
        logic [3:0][W-1:0]  w;
        logic               has_last;
        logic [W-1:0]       exp_sum;
        logic               exp_ok;
        logic               exp_len;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] d,
                                input logic has_last, input logic [W-1:0] s,
                                input logic ok, input logic len);
        vec_t v;
        v.n = n;
        v.w[0] = a;
        v.w[1] = b;
        v.w[2] = c;
        v.w[3] = d;
        v.has_last = has_last;
        v.exp_sum = s;
        v.exp_ok = ok;
        v.exp_len = len;
        return v;
    endfunction

    // Reference: add everything as plain integers, then fold carries back until it fits.
    function automatic logic [W-1:0] ones_sum(input logic [W-1:0] ws[$]);
        int unsigned total = 0;
        foreach (ws[i]) total += ws[i];
        while (total > 15) total = (total & 15) + (total >> 4);
        return 4'(total);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic l);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", in_ready, 1);
        check("out_valid_pre", out_valid, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_report();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    task automatic run_pkt(input logic [W-1:0] ws[$], input logic has_last,
                           input logic [W-1:0] exp_sum, input logic exp_ok,
                           input logic exp_len, input int delay);
        foreach (ws[i]) send_word(ws[i], has_last && (i == ws.size() - 1));
        check("out_valid", out_valid, 1);
        check("out_sum", out_sum, exp_sum);
        check("out_ok", out_ok, exp_ok);
        check("out_len_err", out_len_err, exp_len);
        check("in_ready_report", in_ready, 0);
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            // Offer a word during the stall; it must not be taken.
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_sum", out_sum, exp_sum);
            check("stall_ok", out_ok, exp_ok);
            check("stall_len", out_len_err, exp_len);
            check("stall_ready", in_ready, 0);
        end
        finish_report();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] q[$];
        logic         hl;
        logic [W-1:0] es;
        int           n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        vecs[0] = mk(3, 4'h3, 4'h5, 4'h7, 4'h0, 1, 4'hF, 1, 0);
        vecs[1] = mk(2, 4'hF, 4'hF, 4'h0, 4'h0, 1, 4'hF, 1, 0);
        vecs[2] = mk(2, 4'h1, 4'h2, 4'h0, 4'h0, 1, 4'h3, 0, 0);
        vecs[3] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 1, 4'h0, 0, 0);
        vecs[4] = mk(4, 4'h1, 4'h2, 4'h3, 4'h9, 1, 4'hF, 1, 0);
        vecs[5] = mk(4, 4'h1, 4'h1, 4'h1, 4'h1, 0, 4'h4, 0, 1);
        vecs[6] = mk(4, 4'hF, 4'hF, 4'hF, 4'hF, 0, 4'hF, 0, 1);
        vecs[7] = mk(2, 4'h8, 4'h9, 4'h0, 4'h0, 1, 4'h2, 0, 0);
        vecs[8] = mk(1, 4'hE, 4'h0, 4'h0, 4'h0, 1, 4'hE, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_ok", out_ok, 0);
        check("rst_out_len_err", out_len_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        for (int v = 0; v < 9; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].w[i]);
            run_pkt(q, vecs[v].has_last, vecs[v].exp_sum, vecs[v].exp_ok, vecs[v].exp_len,
                    v % 2);
        end

        // Stalled report, then a follow-on packet must start from a clean accumulator.
        q = '{4'h3, 4'h5, 4'h7};
        run_pkt(q, 1'b1, 4'hF, 1'b1, 1'b0, 3);
        q = '{4'h1, 4'h2};
        run_pkt(q, 1'b1, 4'h3, 1'b0, 1'b0, 0);

        // Five words without last: overflow on the 4th, the 5th starts a new packet.
        q = '{4'h2, 4'h4, 4'h6, 4'h8};
        run_pkt(q, 1'b0, 4'h5, 1'b0, 1'b1, 1);
        q = '{4'hA};
        run_pkt(q, 1'b1, 4'hA, 1'b0, 1'b0, 0);

        // Reset mid-packet discards the partial sum.
        send_word(4'h9, 1'b0);
        send_word(4'h4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midpkt_rst_valid", out_valid, 0);
        check("midpkt_rst_sum", out_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midpkt_rst_ready", in_ready, 1);
        q = '{4'h3, 4'h5, 4'h7};
        run_pkt(q, 1'b1, 4'hF, 1'b1, 1'b0, 0);

        // Reset while a result is pending clears the outputs immediately.
        send_word(4'h3, 1'b0);
        send_word(4'h5, 1'b0);
        send_word(4'h7, 1'b1);
        check("pre_rst_sum", out_sum, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("report_rst_valid", out_valid, 0);
        check("report_rst_sum", out_sum, 0);
        check("report_rst_ok", out_ok, 0);
        check("report_rst_len", out_len_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q = '{4'h3, 4'h5, 4'h7};
        run_pkt(q, 1'b1, 4'hF, 1'b1, 1'b0, 0);

        for (int p = 0; p < 40; p++) begin
            q.delete();
            hl = ($urandom_range(0, 5) != 0);
            n  = hl ? int'($urandom_range(1, MW)) : int'(MW);
            for (int i = 0; i < n; i++) q.push_back(4'($urandom));
            if (hl && n >= 2 && $urandom_range(0, 1) == 1) begin
                // Replace the last word with a valid checksum over the rest.
                q.pop_back();
                es = ~ones_sum(q);
                q.push_back(es);
            end
            es = ones_sum(q);
            run_pkt(q, hl, es, hl && (es == 4'hF), !hl, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
